// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked add/subtract pipeline, one CW-bit chunk resolved per stage,
// with a valid bit per stage and a global stall driven by the output handshake.
module pipelined_adder #(
   parameter int WIDTH  = 14,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH:0]   sum,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int CW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   logic [WIDTH-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
   logic [WIDTH-1:0] a_d [STAGES], b_d [STAGES], s_d [STAGES], s_p [STAGES];
   logic             c_q [STAGES], op_q [STAGES], v_q [STAGES];
   logic             c_d [STAGES], op_d [STAGES], v_d [STAGES], c_p [STAGES];
   logic [CW:0]      add;
   logic             stall;

   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = v_q[L];
   // top bit is carry for add, inverted carry (borrow) for subtract
   assign sum       = {c_q[L] ^ op_q[L], s_q[L]};

   always_comb begin
      a_d[0]  = a;
      b_d[0]  = op ? ~b : b;
      op_d[0] = op;
      v_d[0]  = in_valid;
      s_p[0]  = '0;
      c_p[0]  = op;
      for (int i = 1; i < STAGES; i++) begin
         a_d[i]  = a_q[i-1];
         b_d[i]  = b_q[i-1];
         op_d[i] = op_q[i-1];
         v_d[i]  = v_q[i-1];
         s_p[i]  = s_q[i-1];
         c_p[i]  = c_q[i-1];
      end
      add = '0;
      for (int i = 0; i < STAGES; i++) begin
         add    = {1'b0, a_d[i][i*CW +: CW]} + {1'b0, b_d[i][i*CW +: CW]} + (CW+1)'(c_p[i]);
         s_d[i] = s_p[i] | (WIDTH'(add[CW-1:0]) << (i*CW));
         c_d[i] = add[CW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            a_q[i]  <= '0;
            b_q[i]  <= '0;
            s_q[i]  <= '0;
            c_q[i]  <= 1'b0;
            op_q[i] <= 1'b0;
            v_q[i]  <= 1'b0;
         end
      end else if (!stall) begin
         for (int i = 0; i < STAGES; i++) begin
            a_q[i]  <= a_d[i];
            b_q[i]  <= b_d[i];
            s_q[i]  <= s_d[i];
            c_q[i]  <= c_d[i];
            op_q[i] <= op_d[i];
            v_q[i]  <= v_d[i];
         end
      end
   end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks on a 2-stage instance plus scoreboarded random
// traffic through 1-, 2- and 7-stage instances sharing one stimulus stream.
module tb_pipelined_adder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] a = '0, b = '0;
   logic        op = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        rdy1, rdy2, rdy7, ov1, ov2, ov7;
   logic [14:0] sum1, sum2, sum7;
   logic [14:0] q1 [$], q2 [$], q7 [$];
   logic        chk_en = 1'b0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(14), .STAGES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
      .in_valid(in_valid), .in_ready(rdy1), .sum(sum1), .out_valid(ov1), .out_ready(out_ready));
   pipelined_adder #(.WIDTH(14), .STAGES(2)) u_s2 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
      .in_valid(in_valid), .in_ready(rdy2), .sum(sum2), .out_valid(ov2), .out_ready(out_ready));
   pipelined_adder #(.WIDTH(14), .STAGES(7)) u_s7 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
      .in_valid(in_valid), .in_ready(rdy7), .sum(sum7), .out_valid(ov7), .out_ready(out_ready));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] model(input logic [13:0] x, input logic [13:0] y, input logic o);
      return o ? {x < y, 14'(x - y)} : {1'b0, x} + {1'b0, y};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [13:0] x, input logic [13:0] y, input logic o, input logic [14:0] exp);
      a = x; b = y; op = o; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("lat_not_early", 32'(ov2), 0);
      step();
      check("lat_valid", 32'(ov2), 1);
      check("vec_sum", 32'(sum2), 32'(exp));
      step();
      check("lat_drop", 32'(ov2), 0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (in_valid && rdy1) q1.push_back(model(a, b, op));
         if (in_valid && rdy2) q2.push_back(model(a, b, op));
         if (in_valid && rdy7) q7.push_back(model(a, b, op));
         if (ov1 && out_ready) begin
            if (q1.size() == 0) check("s1_extra", 1, 0);
            else check("s1_sum", 32'(sum1), 32'(q1.pop_front()));
         end
         if (ov2 && out_ready) begin
            if (q2.size() == 0) check("s2_extra", 1, 0);
            else check("s2_sum", 32'(sum2), 32'(q2.pop_front()));
         end
         if (ov7 && out_ready) begin
            if (q7.size() == 0) check("s7_extra", 1, 0);
            else check("s7_sum", 32'(sum7), 32'(q7.pop_front()));
         end
      end
   end

   initial begin
      step();
      step();
      check("rst_ov", 32'(ov2), 0);
      check("rst_sum", 32'(sum2), 0);
      check("rst_ready", 32'(rdy2), 1);
      rst_n = 1'b1;
      step();
      check("post_rst_ready", 32'(rdy2), 1);

      single(14'd1, 14'd1, 1'b0, 15'd2);
      single(14'd16383, 14'd16383, 1'b0, 15'd32766);
      single(14'd16383, 14'd1, 1'b0, 15'd16384);
      single(14'd0, 14'd1, 1'b1, 15'd32767);
      single(14'd10, 14'd10, 1'b1, 15'd0);
      single(14'd20, 14'd10, 1'b1, 15'd10);
      single(14'd5000, 14'd9000, 1'b1, 15'd28768);

      a = 14'd1; b = 14'd1; op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      a = 14'd0; b = 14'd1;
      step();
      check("stream_first_ov", 32'(ov2), 1);
      check("stream_first", 32'(sum2), 2);
      a = 14'd10; b = 14'd10; out_ready = 1'b0;
      #1;
      check("stall_ready", 32'(rdy2), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold", 32'(sum2), 2);
         check("stall_ov", 32'(ov2), 1);
         check("stall_ready", 32'(rdy2), 0);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_ready", 32'(rdy2), 1);
      step();
      in_valid = 1'b0;
      check("stream_second", 32'(sum2), 1);
      step();
      check("stream_third_ov", 32'(ov2), 1);
      check("stream_third", 32'(sum2), 20);
      step();
      check("stream_end_ov", 32'(ov2), 0);

      a = 14'd1; b = 14'd1; in_valid = 1'b1;
      step();
      a = 14'd2; b = 14'd2;
      step();
      a = 14'd5; b = 14'd5; rst_n = 1'b0;
      step();
      check("midrst_ov", 32'(ov2), 0);
      check("midrst_sum", 32'(sum2), 0);
      check("midrst_ready", 32'(rdy2), 1);
      rst_n = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("midrst_no_stale", 32'(ov2), 0);
      end

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         a = 14'($urandom);
         b = 14'($urandom);
         op = 1'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if (i % 500 < 20) begin
            a = (i % 2 == 0) ? 14'd16383 : 14'd0;
            b = (i % 3 == 0) ? 14'd16383 : 14'd1;
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk_en = 1'b0;
      check("s1_drain", 32'(q1.size()), 0);
      check("s2_drain", 32'(q2.size()), 0);
      check("s7_drain", 32'(q7.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 14, operand width in bits; SHALL be a positive multiple of STAGES.
REQ-002 Parameter STAGES, default 2, number of pipeline stages; each stage SHALL resolve one chunk of CW = WIDTH/STAGES bits.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port a  input  WIDTH  operand A, unsigned.
REQ-006 Port b  input  WIDTH  operand B, unsigned.
REQ-007 Port op  input  1  0 = add, 1 = subtract (A - B).
REQ-008 Port in_valid  input  1  operand/op presented this cycle.
REQ-009 Port in_ready  output  1  block accepts operands this cycle.
REQ-010 Port sum  output  WIDTH+1  result.
REQ-011 Port out_valid  output  1  sum holds a valid result.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.

Function
REQ-013 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-014 op=0: sum SHALL equal the full (WIDTH+1)-bit unsigned A+B, with bit WIDTH as carry-out.
REQ-015 op=1: sum[WIDTH-1:0] SHALL equal (A-B) mod 2^WIDTH; sum[WIDTH] SHALL be 1 iff A < B (borrow), else 0.
REQ-016 Subtraction SHALL be realised as A + ~B with carry-in 1 into chunk 0; borrow = NOT final carry-out.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk k of A and of the (possibly inverted) B plus the registered carry from stage k-1, and register the CW-bit partial sum and carry-out.
REQ-018 Unprocessed operand chunks and op SHALL travel with each entry through the stages, so no combinational path spans more than one CW-bit chunk plus one carry.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when no stall occurs.
REQ-020 Throughput SHALL be one result per cycle when out_ready is held 1.
REQ-021 Each stage SHALL carry a valid bit; out_valid SHALL be the valid bit of the last stage.
REQ-022 Stall = out_valid && !out_ready; during stall all stage registers, including sum, SHALL hold unchanged.
REQ-023 in_ready SHALL equal !stall (combinational from out_valid and out_ready); it SHALL NOT depend on in_valid.
REQ-024 When not stalled, a stage with no valid entry SHALL accept a bubble, so empty slots collapse only through normal advance; ordering SHALL be strictly FIFO.
REQ-025 Simultaneous output transfer and input transfer in the same cycle SHALL both occur with no loss or duplication.
REQ-026 in_valid=0 while not stalled SHALL insert a bubble (valid bit 0) into stage 0.
REQ-027 sum SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 STAGES=1 SHALL degenerate to one registered full-width adder with latency 1.

Reset
REQ-029 While rst_n=0 at a rising edge, all stage valid bits SHALL clear to 0; out_valid SHALL be 0 and sum SHALL be 0 from the following cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight entries; none SHALL appear at the output afterwards.
REQ-031 in_ready SHALL be 1 during and immediately after reset (out_valid=0 implies no stall).
REQ-032 Operands presented while rst_n=0 SHALL NOT be accepted.

Verification (WIDTH=14, STAGES=2 unless stated)
REQ-033 a=1,b=1,op=0, one-cycle pulse of in_valid, out_ready=1 -> out_valid=1 exactly 2 cycles later with sum=15'd2, then 0.
REQ-034 a=16383,b=16383,op=0 -> sum=15'd32766; a=16383,b=1,op=0 -> sum=15'd16384 (carry crosses chunk boundary).
REQ-035 a=0,b=1,op=1 -> sum=15'd32767 (borrow=1, low bits 16383); a=10,b=10,op=1 -> sum=15'd0; a=20,b=10,op=1 -> sum=15'd10.
REQ-036 Back-to-back stream (1+1, 0+1, 10+10) with out_ready=0 from first out_valid for 3 cycles -> sum holds 2, in_ready=0 during stall, then results 2,1,20 in order on consecutive cycles.
REQ-037 Two operands in flight, rst_n=0 for one cycle -> out_valid=0 and sum=0 next cycle; no stale result ever emerges.
REQ-038 Randomised $urandom operands/op with random out_ready, repeated for STAGES in {1,2,7} (WIDTH=14) -> every result matches a reference model, in order, with no drop or duplicate.
